sleep_stage_controller: RTL and testbench

Multi-stage sleep/wake state machine for the mood core: it watches the quantised energy and stress indicators, moves the creature through awake, drowsy, light-sleep and deep-sleep stages, and drives the energy counter's increment/decrement enables. It generalises the single-bit awake/asleep controller in three ways: configurable indicator width and thresholds, minimum-dwell timing per stage, and a deep-sleep stage that stress can only lighten, not break. It also counts completed sleep episodes for the behaviour/statistics logic.

---
 rtl/sleep_stage_controller.sv | 182 ++++++++++++++++++
 tb/tb_sleep_stage_controller.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sleep_stage_controller.sv
// Multi-stage sleep/wake controller for the mood core.
// Tracks AWAKE -> DROWSY -> LIGHT -> DEEP using quantised energy and stress
// indicators, drives the energy counter enables and counts sleep episodes.
// All outputs are registered from the decode of the next state.
module sleep_stage_controller #(
    parameter int unsigned IND_W         = 2,
    parameter int unsigned LOW_THR       = 2,
    parameter int unsigned STRESS_THR    = 2,
    parameter int unsigned DROWSY_CYCLES = 4,
    parameter int unsigned DEEP_DELAY    = 16,
    parameter int unsigned MIN_SLEEP     = 8,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned EP_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IND_W-1:0] energy_indicator,
    input  logic [IND_W-1:0] stress_indicator,
    output logic             drowsy,
    output logic             asleep,
    output logic             deep_sleep,
    output logic             en_inc,
    output logic             en_dec,
    output logic             fell_asleep,
    output logic             woke_up,
    output logic [EP_W-1:0]  episodes
);

    typedef enum logic [1:0] {
        StAwake  = 2'd0,
        StDrowsy = 2'd1,
        StLight  = 2'd2,
        StDeep   = 2'd3
    } state_e;

    // Thresholds widened by one bit so a threshold of 2^IND_W is representable.
    localparam logic [IND_W:0]   LowThr    = (IND_W + 1)'(LOW_THR);
    localparam logic [IND_W:0]   StressThr = (IND_W + 1)'(STRESS_THR);
    localparam logic [CNT_W-1:0] DrowsyLim = CNT_W'(DROWSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] DeepLim   = CNT_W'(DEEP_DELAY - 1);
    localparam logic [CNT_W-1:0] SleepLim  = CNT_W'(MIN_SLEEP - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_dwell;
    logic [CNT_W-1:0] w_dwell_next;
    logic [EP_W-1:0]  r_episodes;
    logic [EP_W-1:0]  w_episodes_next;

    logic w_tired;
    logic w_stressed;
    logic w_rested;
    logic w_fell;
    logic w_woke;

    logic w_drowsy;
    logic w_asleep;
    logic w_deep;
    logic w_en_inc;
    logic w_en_dec;

    logic r_drowsy;
    logic r_asleep;
    logic r_deep;
    logic r_en_inc;
    logic r_en_dec;
    logic r_fell;
    logic r_woke;

    // Indicator classification.
    always_comb begin
        w_tired    = ({1'b0, energy_indicator} < LowThr);
        w_stressed = ({1'b0, stress_indicator} >= StressThr);
        w_rested   = (energy_indicator == {IND_W{1'b1}});
    end

    // Next-state, transition pulses and episode counter update.
    always_comb begin
        w_state_next    = r_state;
        w_fell          = 1'b0;
        w_woke          = 1'b0;
        w_episodes_next = r_episodes;
        unique case (r_state)
            StAwake: begin
                if (w_tired && !w_stressed) begin
                    w_state_next = StDrowsy;
                end
            end
            StDrowsy: begin
                if (!w_tired || w_stressed) begin
                    w_state_next = StAwake;
                end else if (r_dwell >= DrowsyLim) begin
                    w_state_next = StLight;
                    w_fell       = 1'b1;
                    if (r_episodes != {EP_W{1'b1}}) begin
                        w_episodes_next = r_episodes + EP_W'(1);
                    end
                end
            end
            StLight: begin
                // Stress beats both a rested wake and the deep-sleep timeout.
                if (w_stressed) begin
                    w_state_next = StAwake;
                    w_woke       = 1'b1;
                end else if (w_rested && (r_dwell >= SleepLim)) begin
                    w_state_next = StAwake;
                    w_woke       = 1'b1;
                end else if (r_dwell >= DeepLim) begin
                    w_state_next = StDeep;
                end
            end
            StDeep: begin
                // Stress only lightens deep sleep; it never wakes directly.
                if (w_stressed) begin
                    w_state_next = StLight;
                end else if (w_rested && (r_dwell >= SleepLim)) begin
                    w_state_next = StAwake;
                    w_woke       = 1'b1;
                end
            end
            default: begin
                w_state_next = StAwake;
            end
        endcase
    end

    // Dwell counter: restart on state change, otherwise saturating count.
    always_comb begin
        w_dwell_next = r_dwell;
        if (w_state_next != r_state) begin
            w_dwell_next = '0;
        end else if (r_dwell != {CNT_W{1'b1}}) begin
            w_dwell_next = r_dwell + CNT_W'(1);
        end
    end

    // Output decode of the next state, registered alongside the state.
    always_comb begin
        w_drowsy = (w_state_next == StDrowsy);
        w_asleep = (w_state_next == StLight) || (w_state_next == StDeep);
        w_deep   = (w_state_next == StDeep);
        w_en_inc = w_asleep;
        w_en_dec = !w_asleep;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StAwake;
            r_dwell    <= '0;
            r_episodes <= '0;
            r_drowsy   <= 1'b0;
            r_asleep   <= 1'b0;
            r_deep     <= 1'b0;
            r_en_inc   <= 1'b0;
            r_en_dec   <= 1'b0;
            r_fell     <= 1'b0;
            r_woke     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_dwell    <= w_dwell_next;
            r_episodes <= w_episodes_next;
            r_drowsy   <= w_drowsy;
            r_asleep   <= w_asleep;
            r_deep     <= w_deep;
            r_en_inc   <= w_en_inc;
            r_en_dec   <= w_en_dec;
            r_fell     <= w_fell;
            r_woke     <= w_woke;
        end
    end

    assign drowsy      = r_drowsy;
    assign asleep      = r_asleep;
    assign deep_sleep  = r_deep;
    assign en_inc      = r_en_inc;
    assign en_dec      = r_en_dec;
    assign fell_asleep = r_fell;
    assign woke_up     = r_woke;
    assign episodes    = r_episodes;

endmodule

// File: tb/tb_sleep_stage_controller.sv
// Self-checking bench for sleep_stage_controller: directed scenarios plus
// randomized bursts, all compared against a stage/time-in-stage model.
module tb_sleep_stage_controller;

    localparam int IND_W         = 2;
    localparam int LOW_THR       = 2;
    localparam int STRESS_THR    = 2;
    localparam int DROWSY_CYCLES = 4;
    localparam int DEEP_DELAY    = 16;
    localparam int MIN_SLEEP     = 8;
    localparam int CNT_W         = 8;
    localparam int EP_W          = 2;
    localparam int EP_MAX        = (1 << EP_W) - 1;
    localparam int CNT_MAX       = (1 << CNT_W) - 1;
    localparam int E_MAX         = (1 << IND_W) - 1;
    localparam int VW            = 7 + EP_W;

    // Model stage numbering.
    localparam int AWAKE  = 0;
    localparam int DROWSY = 1;
    localparam int LIGHT  = 2;
    localparam int DEEP   = 3;

    logic             clk;
    logic             rst;
    logic [IND_W-1:0] energy;
    logic [IND_W-1:0] stress;
    logic             drowsy;
    logic             asleep;
    logic             deep_sleep;
    logic             en_inc;
    logic             en_dec;
    logic             fell_asleep;
    logic             woke_up;
    logic [EP_W-1:0]  episodes;
    logic [VW-1:0]    dut_vec;

    int n_tests;
    int n_fail;

    // Reference model state.
    int m_stage;
    int m_held;
    int m_eps;
    bit m_fell;
    bit m_woke;
    bit m_rst;

    sleep_stage_controller #(
        .IND_W        (IND_W),
        .LOW_THR      (LOW_THR),
        .STRESS_THR   (STRESS_THR),
        .DROWSY_CYCLES(DROWSY_CYCLES),
        .DEEP_DELAY   (DEEP_DELAY),
        .MIN_SLEEP    (MIN_SLEEP),
        .CNT_W        (CNT_W),
        .EP_W         (EP_W)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .energy_indicator(energy),
        .stress_indicator(stress),
        .drowsy          (drowsy),
        .asleep          (asleep),
        .deep_sleep      (deep_sleep),
        .en_inc          (en_inc),
        .en_dec          (en_dec),
        .fell_asleep     (fell_asleep),
        .woke_up         (woke_up),
        .episodes        (episodes)
    );

    assign dut_vec = {drowsy, asleep, deep_sleep, en_inc, en_dec, fell_asleep, woke_up, episodes};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_stage = AWAKE;
        m_held  = 0;
        m_eps   = 0;
        m_fell  = 0;
        m_woke  = 0;
        m_rst   = 1;
    endtask

    // One clock of the behavioural rules; m_held = cycles already spent in stage.
    task automatic model_step(input int e, input int s);
        bit tired;
        bit stressed;
        bit rested;
        int nxt;
        tired    = (e < LOW_THR);
        stressed = (s >= STRESS_THR);
        rested   = (e == E_MAX);
        nxt      = m_stage;
        m_fell   = 0;
        m_woke   = 0;
        m_rst    = 0;
        if (m_stage == AWAKE) begin
            if (tired && !stressed) nxt = DROWSY;
        end else if (m_stage == DROWSY) begin
            if (!tired || stressed) nxt = AWAKE;
            else if (m_held + 1 >= DROWSY_CYCLES) begin
                nxt    = LIGHT;
                m_fell = 1;
                m_eps  = (m_eps + 1 > EP_MAX) ? EP_MAX : m_eps + 1;
            end
        end else if (m_stage == LIGHT) begin
            if (stressed || (rested && m_held + 1 >= MIN_SLEEP)) begin
                nxt    = AWAKE;
                m_woke = 1;
            end else if (m_held + 1 >= DEEP_DELAY) nxt = DEEP;
        end else begin
            if (stressed) nxt = LIGHT;
            else if (rested && m_held + 1 >= MIN_SLEEP) begin
                nxt    = AWAKE;
                m_woke = 1;
            end
        end
        if (nxt != m_stage) m_held = 0;
        else if (m_held < CNT_MAX) m_held = m_held + 1;
        m_stage = nxt;
    endtask

    function automatic logic [VW-1:0] model_vec();
        logic [EP_W-1:0] ep;
        ep = EP_W'(m_eps);
        if (m_rst) return '0;
        return {m_stage == DROWSY, m_stage >= LIGHT, m_stage == DEEP, m_stage >= LIGHT,
                m_stage <= DROWSY, m_fell, m_woke, ep};
    endfunction

    // Drive inputs, take one edge, advance the model, settle past the edge.
    task automatic tick(input int e, input int s);
        energy = IND_W'(e);
        stress = IND_W'(s);
        @(posedge clk);
        if (!rst) model_step(e, s);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic go_light();
        repeat (DROWSY_CYCLES + 1) tick(1, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick($urandom_range(0, E_MAX), $urandom_range(0, E_MAX));
            n_tests++;
            if (dut_vec !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: outputs %b, required all 0", dut_vec);
            end
        end
        @(negedge clk);
        energy = 2'd3;
        stress = 2'd0;
        rst    = 1'b0;
        #1;
        n_tests++;
        if (dut_vec !== '0) begin
            n_fail++;
            $display("FAIL reset_release_preedge: outputs %b, required all 0", dut_vec);
        end
        for (int i = 0; i < 3; i++) begin
            tick(3, 0);
            n_tests++;
            if (en_dec !== 1'b1 || dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL reset_release edge %0d: got %b, expected %b", i + 1, dut_vec,
                         model_vec());
            end
        end
    endtask

    task automatic test_fall_asleep();
        do_reset();
        for (int i = 1; i <= DROWSY_CYCLES + 2; i++) begin
            tick(1, 0);
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL fall_asleep edge %0d: got %b, expected %b", i, dut_vec,
                         model_vec());
            end
            if (i == 1) begin
                n_tests++;
                if (drowsy !== 1'b1 || asleep !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fall_asleep_drowsy: drowsy=%b asleep=%b, required 1 0",
                             drowsy, asleep);
                end
            end
            if (i == DROWSY_CYCLES) begin
                n_tests++;
                if (asleep !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fall_asleep_early: asleep=%b, required 0", asleep);
                end
            end
            if (i == DROWSY_CYCLES + 1) begin
                n_tests++;
                if ({asleep, fell_asleep, en_inc, en_dec, drowsy} !== 5'b11100 ||
                    episodes !== EP_W'(1)) begin
                    n_fail++;
                    $display("FAIL fall_asleep_enter: asleep,fell,inc,dec,drowsy=%b eps=%0d, required 11100 eps=1",
                             {asleep, fell_asleep, en_inc, en_dec, drowsy}, episodes);
                end
            end
            if (i == DROWSY_CYCLES + 2) begin
                n_tests++;
                if (fell_asleep !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fall_asleep_pulse: fell_asleep=%b, required 0", fell_asleep);
                end
            end
        end
    endtask

    task automatic test_aborted();
        do_reset();
        tick(1, 0);
        tick(1, 0);
        for (int i = 0; i < 6; i++) begin
            tick(3, 0);
            n_tests++;
            if (drowsy !== 1'b0 || asleep !== 1'b0 || episodes !== '0 ||
                dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL aborted edge %0d: got %b, expected %b", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_min_sleep();
        do_reset();
        go_light();
        for (int i = 1; i <= MIN_SLEEP + 1; i++) begin
            tick(3, 0);
            n_tests++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL min_sleep edge %0d: got %b, expected %b", i, dut_vec,
                         model_vec());
            end
            n_tests++;
            if (i < MIN_SLEEP && (asleep !== 1'b1 || woke_up !== 1'b0)) begin
                n_fail++;
                $display("FAIL min_sleep_early edge %0d: asleep=%b woke=%b, required 1 0", i,
                         asleep, woke_up);
            end else if (i == MIN_SLEEP && (asleep !== 1'b0 || woke_up !== 1'b1)) begin
                n_fail++;
                $display("FAIL min_sleep_wake: asleep=%b woke=%b, required 0 1", asleep, woke_up);
            end else if (i > MIN_SLEEP && woke_up !== 1'b0) begin
                n_fail++;
                $display("FAIL min_sleep_pulse: woke=%b, required 0", woke_up);
            end
        end
        do_reset();
        go_light();
        tick(1, 2);
        n_tests++;
        if (asleep !== 1'b0 || woke_up !== 1'b1 || en_dec !== 1'b1) begin
            n_fail++;
            $display("FAIL stress_wake: asleep=%b woke=%b en_dec=%b, required 0 1 1", asleep,
                     woke_up, en_dec);
        end
    endtask

    task automatic test_deep();
        // Stress arriving exactly at the deep timeout wakes instead.
        do_reset();
        go_light();
        repeat (DEEP_DELAY - 1) tick(1, 0);
        tick(1, 3);
        n_tests++;
        if (asleep !== 1'b0 || deep_sleep !== 1'b0 || woke_up !== 1'b1) begin
            n_fail++;
            $display("FAIL deep_race: asleep=%b deep=%b woke=%b, required 0 0 1", asleep,
                     deep_sleep, woke_up);
        end
        do_reset();
        go_light();
        for (int i = 1; i <= DEEP_DELAY; i++) begin
            tick(1, 0);
            n_tests++;
            if (deep_sleep !== (i == DEEP_DELAY) || dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL deep_enter edge %0d: deep=%b got %b, expected %b", i, deep_sleep,
                         dut_vec, model_vec());
            end
        end
        // Rested plus stressed in DEEP resolves to LIGHT.
        tick(3, 3);
        n_tests++;
        if (deep_sleep !== 1'b0 || asleep !== 1'b1 || woke_up !== 1'b0) begin
            n_fail++;
            $display("FAIL deep_lighten: deep=%b asleep=%b woke=%b, required 0 1 0", deep_sleep,
                     asleep, woke_up);
        end
        for (int i = 1; i <= MIN_SLEEP; i++) begin
            tick(3, 0);
            n_tests++;
            if (asleep !== (i < MIN_SLEEP) || woke_up !== (i == MIN_SLEEP)) begin
                n_fail++;
                $display("FAIL deep_rewake edge %0d: asleep=%b woke=%b, required %b %b", i,
                         asleep, woke_up, i < MIN_SLEEP, i == MIN_SLEEP);
            end
        end
    endtask

    task automatic test_saturation_async_reset();
        int exp_eps;
        do_reset();
        for (int k = 1; k <= EP_MAX + 2; k++) begin
            go_light();
            exp_eps = (k > EP_MAX) ? EP_MAX : k;
            n_tests++;
            if (fell_asleep !== 1'b1 || episodes !== EP_W'(exp_eps)) begin
                n_fail++;
                $display("FAIL saturation ep %0d: fell=%b episodes=%0d, required 1 %0d", k,
                         fell_asleep, episodes, exp_eps);
            end
            tick(1, 2);
        end
        go_light();
        repeat (DEEP_DELAY + 2) tick(1, 0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (dut_vec !== '0) begin
            n_fail++;
            $display("FAIL async_reset: outputs %b, required all 0", dut_vec);
        end
        @(negedge clk);
        rst = 1'b0;
        tick(3, 0);
        n_tests++;
        if (woke_up !== 1'b0 || en_dec !== 1'b1 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL async_reset_release: got %b, expected %b", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        int mode;
        int len;
        int e;
        int s;
        do_reset();
        for (int b = 0; b < 150; b++) begin
            mode = $urandom_range(0, 3);
            len  = $urandom_range(1, 40);
            if ($urandom_range(0, 29) == 0) do_reset();
            for (int c = 0; c < len; c++) begin
                case (mode)
                    0: begin
                        e = $urandom_range(0, E_MAX);
                        s = $urandom_range(0, E_MAX);
                    end
                    1: begin
                        e = $urandom_range(0, LOW_THR - 1);
                        s = 0;
                    end
                    2: begin
                        e = E_MAX;
                        s = ($urandom_range(0, 9) == 0) ? $urandom_range(0, E_MAX) : 0;
                    end
                    default: begin
                        e = $urandom_range(0, LOW_THR - 1);
                        s = ($urandom_range(0, 7) == 0) ? $urandom_range(STRESS_THR, E_MAX) : 0;
                    end
                endcase
                tick(e, s);
                n_tests++;
                if (dut_vec !== model_vec()) begin
                    n_fail++;
                    $display("FAIL random burst %0d cyc %0d e=%0d s=%0d: got %b, expected %b", b,
                             c, e, s, dut_vec, model_vec());
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        energy  = '0;
        stress  = '0;
        model_reset();
        test_reset();
        test_fall_asleep();
        test_aborted();
        test_min_sleep();
        test_deep();
        test_saturation_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
